can_rx_ahb: RTL

- AHB-slave receive path for the CAN controller; complement of the transmit-side AHB register block.
- Captures completed frames from the CAN receiver into a small FIFO.
- Software reads data, ID and command fields from memory-mapped registers and pops entries.
- Raises an interrupt while frames are pending or an overflow has occurred.

---
 rtl/can_rx_pkg.sv | 32 +++
 rtl/can_rx_ahb_if.sv | 23 ++
 rtl/can_rx_fifo.sv | 77 +++++++
 rtl/can_rx_ahb.sv | 123 ++++++++++++
 4 files changed

// File: rtl/can_rx_pkg.sv
// Shared types and constants for the CAN receive-side AHB register block.
package can_rx_pkg;

    localparam logic [15:0] OFF_DL     = 16'h0000;
    localparam logic [15:0] OFF_DH     = 16'h0004;
    localparam logic [15:0] OFF_CMD    = 16'h0008;
    localparam logic [15:0] OFF_ID     = 16'h000C;
    localparam logic [15:0] OFF_STATUS = 16'h0010;
    localparam logic [15:0] OFF_POP    = 16'h0014;
    localparam logic [15:0] OFF_CTRL   = 16'h0018;

    localparam int unsigned ST_EMPTY   = 8;
    localparam int unsigned ST_FULL    = 9;
    localparam int unsigned ST_OVF     = 10;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_IRQEN = 1;

    typedef struct packed {
        logic [63:0] data;
        logic [28:0] id;
        logic [3:0]  datalen;
        logic        format;
        logic [1:0]  frameType;
    } can_rx_frame_t;

    // CMD register layout, shared with the transmit side.
    function automatic logic [31:0] cmd_word(input can_rx_frame_t f);
        return {20'h0, f.datalen, f.format, f.frameType, 5'h0};
    endfunction

endpackage

// File: rtl/can_rx_ahb_if.sv
// AHB-lite slave bus signals for the CAN receive register block.
interface can_rx_ahb_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
        output HREADY, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
        input  HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/can_rx_fifo.sv
// Receive-frame FIFO with sticky overflow; a pop in the same cycle frees room for a push.
module can_rx_fifo
    import can_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clrOvf,
    input  can_rx_frame_t            din,
    output can_rx_frame_t            dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    can_rx_frame_t    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && (!w_full || w_pop);
    assign w_drop = push && w_full && !w_pop;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clrOvf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign dout     = r_mem[r_rptr];
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = (r_count == '0);
    assign overflow = r_ovf;

endmodule

// File: rtl/can_rx_ahb.sv
// AHB slave register front end for the CAN receive FIFO: address decode, read mux, irq.
module can_rx_ahb
    import can_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter logic [15:0] BASE  = 16'hff20
) (
    input  logic                HCLK,
    input  logic                HRESET,
    can_rx_ahb_if.slave         ahb,
    input  logic                rxValid,
    input  logic [63:0]         rxData,
    input  logic [28:0]         rxId,
    input  logic [3:0]          rxDatalen,
    input  logic                rxFormat,
    input  logic [1:0]          rxFrameType,
    output logic                irq
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic        r_dp_valid;
    logic        r_dp_write;
    logic [15:0] r_dp_addr;
    logic [1:0]  r_ctrl;
    logic        r_irq;

    logic [15:0]      w_off;
    logic             w_wr;
    logic             w_pop;
    logic             w_clr;
    can_rx_frame_t    w_din;
    can_rx_frame_t    w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_ovf;
    logic [31:0]      w_status;
    logic [31:0]      w_rdata;
    logic             w_unused;

    // Address phase capture; IDLE/BUSY or deselect cancels the data phase.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= '0;
        end else begin
            r_dp_valid <= ahb.HSEL && ahb.HTRANS[1];
            r_dp_write <= ahb.HWRITE;
            r_dp_addr  <= ahb.HADDR[15:0];
        end
    end

    assign w_off = r_dp_addr - BASE;
    assign w_wr  = r_dp_valid && r_dp_write;
    assign w_pop = w_wr && (w_off == OFF_POP);
    assign w_clr = w_wr && (w_off == OFF_STATUS) && ahb.HWDATA[ST_OVF];

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_ctrl <= '0;
        end else if (w_wr && (w_off == OFF_CTRL)) begin
            r_ctrl <= ahb.HWDATA[1:0];
        end
    end

    assign w_din = '{data: rxData, id: rxId, datalen: rxDatalen,
                     format: rxFormat, frameType: rxFrameType};

    can_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (HCLK),
        .rst_n    (HRESET),
        .push     (rxValid && r_ctrl[CTRL_EN]),
        .pop      (w_pop),
        .clrOvf   (w_clr),
        .din      (w_din),
        .dout     (w_head),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty),
        .overflow (w_ovf)
    );

    always_comb begin
        w_status              = '0;
        w_status[CNT_W-1:0]   = w_count;
        w_status[ST_EMPTY]    = w_empty;
        w_status[ST_FULL]     = w_full;
        w_status[ST_OVF]      = w_ovf;
    end

    // Read mux; head fields read as zero while the FIFO is empty.
    always_comb begin
        w_rdata = '0;
        if (r_dp_valid && !r_dp_write) begin
            case (w_off)
                OFF_DL:     w_rdata = w_empty ? 32'h0 : w_head.data[31:0];
                OFF_DH:     w_rdata = w_empty ? 32'h0 : w_head.data[63:32];
                OFF_CMD:    w_rdata = w_empty ? 32'h0 : cmd_word(w_head);
                OFF_ID:     w_rdata = w_empty ? 32'h0 : {w_head.id, 3'b000};
                OFF_STATUS: w_rdata = w_status;
                OFF_CTRL:   w_rdata = {30'h0, r_ctrl};
                default:    w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ctrl[CTRL_IRQEN] && (!w_empty || w_ovf);
        end
    end

    assign ahb.HRDATA = w_rdata;
    assign ahb.HREADY = 1'b1;
    assign ahb.HRESP  = 2'b00;
    assign irq        = r_irq;

    assign w_unused = ^{ahb.HADDR[31:16], ahb.HTRANS[0], ahb.HSIZE, ahb.HBURST, ahb.HWDATA};

endmodule
